// File: rtl/cdc_pkg.sv
// Shared constants for the four-phase request/acknowledge CDC blocks:
// FSM state encoding, default synchronizer depth and a depth guard.
package cdc_pkg;

    // Responder FSM state encoding.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OFFER = 2'd1;
    localparam logic [1:0] ST_ACK   = 2'd2;

    // Default number of flip-flops in a request synchronizer.
    localparam int SYNC_STAGES_DEFAULT = 2;

    // A synchronizer shallower than two flops gives no metastability
    // protection, so any smaller request is raised to two.
    function automatic int sync_depth(input int n);
        return (n < 2) ? 2 : n;
    endfunction

endpackage

// File: rtl/cdc_sync_ff_n.sv
// N-stage flip-flop synchronizer for a single level signal crossing into
// the clk domain. Every stage resets to 0.
module cdc_sync_ff_n #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [N-1:0] sync_q;
    logic [N-1:0] sync_d;

    // Stage 0 samples the asynchronous input; each later stage samples the one before it.
    assign sync_d[0] = d_i;
    generate
        for (genvar gi = 1; gi < N; gi++) begin : g_stage
            assign sync_d[gi] = sync_q[gi-1];
        end
    endgenerate

    // Shift register of synchronizer flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[N-1];

endmodule

// File: rtl/cdc_rqack_responder.sv
// Responder end of a four-phase req/ack crossing. The request level is
// synchronized, the bundled word is captured once when leaving IDLE, offered
// locally over valid/ready, and acknowledged with a registered level.
module cdc_rqack_responder
    import cdc_pkg::*;
#(
    parameter int DW          = 32,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_async,
    input  logic [DW-1:0] data_async,
    output logic          ack_async,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    input  logic          rd_ready,
    output logic          busy,
    output logic          proto_err
);

    localparam int SYNC_N = sync_depth(SYNC_STAGES);

    logic          req_sync;
    logic [1:0]    state_q,     state_d;
    logic          ack_q,       ack_d;
    logic          rd_valid_q,  rd_valid_d;
    logic [DW-1:0] rd_data_q,   rd_data_d;
    logic          proto_err_q, proto_err_d;

    // Only the request is synchronized; the data word is quasi-static by
    // protocol whenever it is sampled.
    cdc_sync_ff_n #(
        .N (SYNC_N)
    ) u_req_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (req_async),
        .q_o   (req_sync)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a ready in OFFER wins over a simultaneous request drop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_sync) begin
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (rd_ready) begin
                    state_d = ST_ACK;
                end else if (!req_sync) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACK: begin
                if (!req_sync) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output next-values derived from the upcoming state so every output is a plain flop.
    always_comb begin
        ack_d       = (state_d == ST_ACK);
        rd_valid_d  = (state_d == ST_OFFER);
        rd_data_d   = rd_data_q;
        proto_err_d = proto_err_q;
        if ((state_q == ST_IDLE) && (state_d == ST_OFFER)) begin
            rd_data_d = data_async;
        end
        if ((state_q == ST_OFFER) && (state_d == ST_IDLE)) begin
            proto_err_d = 1'b1;
        end
    end

    // Output registers; proto_err is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q       <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            proto_err_q <= 1'b0;
        end else begin
            ack_q       <= ack_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign ack_async = ack_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign proto_err = proto_err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cdc_rqack_responder.sv
// Directed bench for cdc_rqack_responder with SYNC_STAGES=2: request to
// rd_valid takes 3 edges, request drop to ack drop takes 3 edges.
module tb_cdc_rqack_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_async = 1'b0;
    logic [31:0] data_async = '0;
    logic        ack_async;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_ready = 1'b0;
    logic        busy;
    logic        proto_err;

    int n_vec = 0;
    int n_err = 0;

    cdc_rqack_responder #(
        .DW          (32),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_async  (req_async),
        .data_async (data_async),
        .ack_async  (ack_async),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_ready   (rd_ready),
        .busy       (busy),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_async = 1'b0; rd_ready = 1'b0; data_async = 32'hFFFF_FFFF;
        repeat (3) tick();
        n_vec++; if (ack_async !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b want 0", ack_async); end
        n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", rd_valid); end
        n_vec++; if (rd_data !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", rd_data); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", proto_err); end
        rst_n = 1'b1;
        repeat (2) tick();
        $display("reset: outputs checked idle");
    endtask

    task automatic test_basic();
        rd_ready = 1'b1; data_async = 32'hDEAD_BEEF; req_async = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            n_vec++; if (rd_valid !== (e == 3)) begin n_err++; $display("FAIL basic_valid_e%0d: got %b want %b", e, rd_valid, (e == 3)); end
        end
        n_vec++; if (rd_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL basic_data: got %h want deadbeef", rd_data); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b want 1", busy); end
        n_vec++; if (ack_async !== 1'b0) begin n_err++; $display("FAIL basic_ack_early: got %b want 0", ack_async); end
        tick();
        n_vec++; if (ack_async !== 1'b1) begin n_err++; $display("FAIL basic_ack_rise: got %b want 1", ack_async); end
        n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_drop: got %b want 0", rd_valid); end
        tick();
        req_async = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            tick();
            n_vec++; if (ack_async !== (e < 3)) begin n_err++; $display("FAIL basic_ack_fall_e%0d: got %b want %b", e, ack_async, (e < 3)); end
            n_vec++; if (busy !== (e < 3)) begin n_err++; $display("FAIL basic_busy_fall_e%0d: got %b want %b", e, busy, (e < 3)); end
        end
        $display("basic: word deadbeef transferred and acknowledged");
    endtask

    task automatic test_backpressure();
        rd_ready = 1'b0; data_async = 32'h1234_5678; req_async = 1'b1;
        repeat (3) tick();
        n_vec++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid: got %b want 1", rd_valid); end
        for (int c = 0; c < 10; c++) begin
            tick();
            n_vec++; if (rd_valid !== 1'b1 || rd_data !== 32'h1234_5678 || ack_async !== 1'b0) begin
                n_err++; $display("FAIL bp_hold_c%0d: got valid=%b data=%h ack=%b want 1 12345678 0", c, rd_valid, rd_data, ack_async);
            end
        end
        rd_ready = 1'b1;
        tick();
        n_vec++; if (ack_async !== 1'b1) begin n_err++; $display("FAIL bp_ack: got %b want 1", ack_async); end
        req_async = 1'b0;
        repeat (3) tick();
        n_vec++; if (ack_async !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL bp_done: got ack=%b busy=%b want 0 0", ack_async, busy); end
        $display("backpressure: 10 stall cycles held, then acknowledged");
    endtask

    task automatic test_simultaneous();
        rd_ready = 1'b0; data_async = 32'h0000_0077; req_async = 1'b1;
        repeat (3) tick();
        req_async = 1'b0;
        repeat (2) tick();
        // req_sync is low now; ready arrives on the very edge that would withdraw.
        rd_ready = 1'b1;
        tick();
        n_vec++; if (ack_async !== 1'b1 || rd_valid !== 1'b0) begin n_err++; $display("FAIL sim_ack: got ack=%b valid=%b want 1 0", ack_async, rd_valid); end
        tick();
        n_vec++; if (ack_async !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL sim_ack_pulse: got ack=%b busy=%b want 0 0", ack_async, busy); end
        n_vec++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL sim_err: got %b want 0", proto_err); end
        $display("simultaneous: ready beat withdrawal, single-cycle ack");
    endtask

    task automatic test_withdrawal();
        rd_ready = 1'b0; data_async = 32'h0000_A5A5; req_async = 1'b1;
        repeat (3) tick();
        req_async = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            tick();
            n_vec++; if (rd_valid !== (e < 3) || proto_err !== (e == 3)) begin
                n_err++; $display("FAIL wd_e%0d: got valid=%b err=%b want %b %b", e, rd_valid, proto_err, (e < 3), (e == 3));
            end
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            n_vec++; if (ack_async !== 1'b0 || proto_err !== 1'b1) begin n_err++; $display("FAIL wd_after_c%0d: got ack=%b err=%b want 0 1", c, ack_async, proto_err); end
        end
        rd_ready = 1'b1; data_async = 32'h0000_0005; req_async = 1'b1;
        repeat (3) tick();
        n_vec++; if (rd_valid !== 1'b1 || rd_data !== 32'h5) begin n_err++; $display("FAIL wd_next: got valid=%b data=%h want 1 00000005", rd_valid, rd_data); end
        tick();
        n_vec++; if (ack_async !== 1'b1 || proto_err !== 1'b1) begin n_err++; $display("FAIL wd_next_ack: got ack=%b err=%b want 1 1", ack_async, proto_err); end
        req_async = 1'b0;
        repeat (3) tick();
        n_vec++; if (ack_async !== 1'b0) begin n_err++; $display("FAIL wd_next_done: got %b want 0", ack_async); end
        $display("withdrawal: sticky error set, next word 5 transferred");
    endtask

    task automatic test_reset_mid();
        int xfers;
        rd_ready = 1'b0; data_async = 32'h0000_0099; req_async = 1'b1;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        n_vec++; if (rd_valid !== 1'b0 || busy !== 1'b0 || ack_async !== 1'b0 || rd_data !== 32'h0 || proto_err !== 1'b0) begin
            n_err++; $display("FAIL rst_offer: got valid=%b busy=%b ack=%b data=%h err=%b want all 0", rd_valid, busy, ack_async, rd_data, proto_err);
        end
        repeat (2) tick();
        rd_ready = 1'b1;
        rst_n = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            n_vec++; if (rd_valid !== (e == 3)) begin n_err++; $display("FAIL rst_refill_e%0d: got %b want %b", e, rd_valid, (e == 3)); end
        end
        tick();
        n_vec++; if (ack_async !== 1'b1) begin n_err++; $display("FAIL rst_reach_ack: got %b want 1", ack_async); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (ack_async !== 1'b0 || busy !== 1'b0 || rd_valid !== 1'b0) begin
            n_err++; $display("FAIL rst_ack: got ack=%b busy=%b valid=%b want 0 0 0", ack_async, busy, rd_valid);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        xfers = 0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (e == 3) begin
                n_vec++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL rst_release_valid: got %b want 1", rd_valid); end
            end
            if (rd_valid === 1'b1 && rd_ready === 1'b1) xfers++;
        end
        n_vec++; if (xfers != 1) begin n_err++; $display("FAIL rst_one_xfer: got %0d want 1", xfers); end
        req_async = 1'b0;
        repeat (3) tick();
        n_vec++; if (ack_async !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rst_done: got ack=%b busy=%b want 0 0", ack_async, busy); end
        $display("reset_mid: aborts in OFFER and ACK, one transfer after release");
    endtask

    task automatic test_back_to_back();
        logic [31:0] cap [0:15];
        int          n_cap;
        int          ack_rises;
        int          k;
        int          phase;
        logic        ack_prev;
        n_cap = 0; ack_rises = 0; k = 0; phase = 0; ack_prev = ack_async;
        rd_ready = 1'b0;
        for (int c = 0; c < 2000 && k < 8; c++) begin
            tick();
            if (ack_async === 1'b1 && ack_prev === 1'b0) ack_rises++;
            ack_prev = ack_async;
            case (phase)
                0: begin data_async = k; req_async = 1'b1; phase = 1; end
                1: if (ack_async === 1'b1) begin req_async = 1'b0; phase = 2; end
                2: if (ack_async === 1'b0) begin k++; phase = 0; end
                default: phase = 0;
            endcase
            rd_ready = ($urandom_range(0, 2) == 0);
            if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
                if (n_cap < 16) cap[n_cap] = rd_data;
                n_cap++;
            end
        end
        n_vec++; if (k != 8) begin n_err++; $display("FAIL b2b_timeout: got %0d done want 8", k); end
        n_vec++; if (n_cap != 8) begin n_err++; $display("FAIL b2b_count: got %0d want 8", n_cap); end
        n_vec++; if (ack_rises != 8) begin n_err++; $display("FAIL b2b_ack_rises: got %0d want 8", ack_rises); end
        for (int i = 0; i < 8 && i < n_cap; i++) begin
            n_vec++; if (cap[i] !== 32'(i)) begin n_err++; $display("FAIL b2b_data_%0d: got %h want %h", i, cap[i], 32'(i)); end
        end
        $display("back_to_back: %0d transfers, %0d ack pulses", n_cap, ack_rises);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_simultaneous();
        test_withdrawal();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
